// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } arb_state_t;

    // Index width for a requester count; one bit minimum so N_REQ=1 still has a signal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART transmitter arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until req_ack; tx side paced by tx_done_tick.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 3
);

    logic [N_REQ-1:0]                       req;
    logic [uart_arb_pkg::BYTE_W*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]                       req_last;
    logic [N_REQ-1:0]                       req_ack;
    logic [N_REQ-1:0]                       grant;
    logic                                   tx_start;
    logic [uart_arb_pkg::BYTE_W-1:0]        tx_byte;
    logic                                   tx_done_tick;
    logic                                   busy;
    logic                                   timeout_tick;

    // Arbiter side.
    modport master (
        input  req, req_data, req_last, tx_done_tick,
        output req_ack, grant, tx_start, tx_byte, busy, timeout_tick
    );

    // Requesters plus transmitter side.
    modport slave (
        output req, req_data, req_last, tx_done_tick,
        input  req_ack, grant, tx_start, tx_byte, busy, timeout_tick
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; result is only consumed while the arbiter is idle.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             vld
);

    logic [IDX_W-1:0] k;

    // Walk candidates from farthest to nearest so the nearest set bit after ptr overwrites.
    always_comb begin
        win     = '0;
        win_idx = '0;
        vld     = 1'b0;
        k       = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = IDX_W'((int'(ptr) + i) % N_REQ);
            if (req[k]) begin
                win     = '0;
                win[k]  = 1'b1;
                win_idx = k;
                vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters, round-robin per message (UART_ARB_TIMEOUT_EN adds stall revocation).
// Latency: req->grant 1 clk, grant->tx_start/req_ack 1 clk, tx_done_tick->next tx_start 2 clk.
// Backpressure: requester holds req/data until req_ack; one byte in flight until tx_done_tick.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = idx_w(N_REQ);

    arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
    logic               tx_start_q, tx_start_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    logic               owner_req;
    logic               owner_last;
    logic [BYTE_W-1:0]  owner_byte;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]        cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .vld     (pick_vld)
    );

    // Mux out the current owner's request, last flag and byte.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req  = bus.req[i];
                owner_last = bus.req_last[i];
                owner_byte = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and registered-output values; arbitration only happens in IDLE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_win;
                    owner_d = pick_idx;
                    state_d = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (owner_req) begin
                    tx_byte_d      = owner_byte;
                    tx_start_d     = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    last_d         = owner_last;
                    state_d        = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    // Owner stalled too long mid-message: revoke without acking.
                    tmo_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            WAIT_DONE: begin
                if (bus.tx_done_tick) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_q;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    // State and output registers; reset leaves the pointer so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            last_q     <= 1'b0;
            tx_byte_q  <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.req_ack  = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.busy     = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_tick = tmo_q;
`else
    assign bus.timeout_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, multi-byte, gap, reset, round-robin, timeout.
// Latency: checks 1-cycle grant, 1-cycle start after grant, 2-cycle restart after done.
// Backpressure: bench acts as requesters and as the transmitter's done pulse source.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 20;
    localparam int GAP = 10;
`else
    localparam int TMO = 65535;
    localparam int GAP = 50;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    uart_tx_arbiter_if #(.N_REQ(3)) bus ();

    uart_tx_arbiter #(
        .N_REQ       (3),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        bus.req_data[i*8 +: 8] = d;
        bus.req_last[i]        = l;
    endtask

    // Returns the number of edges until tx_start is seen (0 = never within budget).
    task automatic wait_start(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (bus.tx_start === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({tag, "_start_seen"}, 32'(n != 0), 32'd1);
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.grant !== 3'b000) begin
                n = i;
                break;
            end
        end
        chk({tag, "_grant_seen"}, 32'(n != 0), 32'd1);
    endtask

    task automatic pulse_done();
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
    endtask

    initial begin
        int           n;
        int           starts;
        int           lost;
        int           tmos;
        logic [7:0]   msg [3];
        logic [2:0]   oh;

        msg[0] = 8'h54;
        msg[1] = 8'h32;
        msg[2] = 8'h35;

        reset            = 1'b1;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.tx_done_tick = 1'b0;
        repeat (3) tick();
        chk("rst_grant",    32'(bus.grant),        32'h0);
        chk("rst_busy",     32'(bus.busy),         32'h0);
        chk("rst_tx_start", 32'(bus.tx_start),     32'h0);
        chk("rst_ack",      32'(bus.req_ack),      32'h0);
        chk("rst_tx_byte",  32'(bus.tx_byte),      32'h0);
        chk("rst_timeout",  32'(bus.timeout_tick), 32'h0);
        reset = 1'b0;
        tick();

        // tx_done_tick while idle must do nothing.
        pulse_done();
        tick();
        chk("idle_done_grant", 32'(bus.grant),    32'h0);
        chk("idle_done_start", 32'(bus.tx_start), 32'h0);

        // Single requester, single byte, done 160 cycles after tx_start.
        set_req(0, 8'h41, 1'b1);
        bus.req = 3'b001;
        tick();
        chk("t1_grant",       32'(bus.grant),    32'h1);
        chk("t1_busy",        32'(bus.busy),     32'h1);
        chk("t1_early_start", 32'(bus.tx_start), 32'h0);
        tick();
        chk("t1_start",       32'(bus.tx_start), 32'h1);
        chk("t1_ack",         32'(bus.req_ack),  32'h1);
        chk("t1_byte",        32'(bus.tx_byte),  32'h41);
        bus.req = 3'b000;
        tick();
        chk("t1_start_pulse", 32'(bus.tx_start), 32'h0);
        chk("t1_ack_pulse",   32'(bus.req_ack),  32'h0);
        repeat (158) tick();
        chk("t1_byte_stable", 32'(bus.tx_byte),  32'h41);
        chk("t1_grant_held",  32'(bus.grant),    32'h1);
        pulse_done();
        chk("t1_release_grant", 32'(bus.grant), 32'h0);
        chk("t1_release_busy",  32'(bus.busy),  32'h0);

        // Requester 1 sends three bytes while requester 0 waits; pointer is 0 so 1 wins.
        set_req(0, 8'hAA, 1'b1);
        set_req(1, msg[0], 1'b0);
        bus.req = 3'b011;
        tick();
        chk("t2_grant", 32'(bus.grant), 32'h2);
        for (int k = 0; k < 3; k++) begin
            wait_start("t2", n);
            chk("t2_latency", 32'(n),            32'd1);
            chk("t2_byte",    32'(bus.tx_byte),  32'(msg[k]));
            chk("t2_ack",     32'(bus.req_ack),  32'h2);
            if (k < 2) set_req(1, msg[k+1], (k == 1));
            else       bus.req[1] = 1'b0;
            repeat (10) tick();
            chk("t2_grant_held", 32'(bus.grant), 32'h2);
            pulse_done();
        end
        chk("t2_idle_gap", 32'(bus.grant), 32'h0);
        tick();
        chk("t2_next_owner", 32'(bus.grant), 32'h1);
        wait_start("t2b", n);
        chk("t2b_byte", 32'(bus.tx_byte), 32'hAA);
        chk("t2b_ack",  32'(bus.req_ack), 32'h1);
        bus.req[0] = 1'b0;
        repeat (3) tick();
        pulse_done();
        chk("t2b_release", 32'(bus.grant), 32'h0);

        // Mid-message gap on requester 2; a stray done during the gap is ignored.
        set_req(2, 8'h10, 1'b0);
        bus.req = 3'b100;
        tick();
        chk("t3_grant", 32'(bus.grant), 32'h4);
        wait_start("t3", n);
        chk("t3_byte", 32'(bus.tx_byte), 32'h10);
        chk("t3_ack",  32'(bus.req_ack), 32'h4);
        bus.req[2] = 1'b0;
        repeat (3) tick();
        pulse_done();
        starts = 0;
        lost   = 0;
        tmos   = 0;
        for (int i = 0; i < GAP; i++) begin
            bus.tx_done_tick = (i == 5);
            tick();
            if (bus.tx_start !== 1'b0) starts++;
            if (bus.grant !== 3'b100) lost++;
            if (bus.timeout_tick !== 1'b0) tmos++;
        end
        bus.tx_done_tick = 1'b0;
        chk("t3_gap_starts",   32'(starts), 32'd0);
        chk("t3_gap_lost",     32'(lost),   32'd0);
        chk("t3_gap_timeouts", 32'(tmos),   32'd0);
        set_req(2, 8'h20, 1'b1);
        bus.req[2] = 1'b1;
        wait_start("t3r", n);
        chk("t3r_latency", 32'(n),           32'd1);
        chk("t3r_byte",    32'(bus.tx_byte), 32'h20);
        chk("t3r_ack",     32'(bus.req_ack), 32'h4);
        bus.req = 3'b000;
        pulse_done();
        chk("t3r_release", 32'(bus.grant), 32'h0);

        // All request; reset lands while requester 0's byte is in flight.
        set_req(0, 8'h01, 1'b1);
        set_req(1, 8'h02, 1'b1);
        set_req(2, 8'h03, 1'b1);
        bus.req = 3'b111;
        tick();
        chk("t4_grant", 32'(bus.grant), 32'h1);
        wait_start("t4", n);
        chk("t4_ack", 32'(bus.req_ack), 32'h1);
        reset = 1'b1;
        #1;
        chk("t4_rst_grant",   32'(bus.grant),        32'h0);
        chk("t4_rst_busy",    32'(bus.busy),         32'h0);
        chk("t4_rst_start",   32'(bus.tx_start),     32'h0);
        chk("t4_rst_ack",     32'(bus.req_ack),      32'h0);
        chk("t4_rst_byte",    32'(bus.tx_byte),      32'h0);
        chk("t4_rst_timeout", 32'(bus.timeout_tick), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Continuous single-byte requests from all three: expect 0,1,2,0,1,2.
        for (int m = 0; m < 6; m++) begin
            oh = 3'b001 << (m % 3);
            wait_grant("rr");
            chk("rr_grant", 32'(bus.grant), 32'(oh));
            wait_start("rr", n);
            chk("rr_byte", 32'(bus.tx_byte), 32'((m % 3) + 1));
            chk("rr_ack",  32'(bus.req_ack), 32'(oh));
            repeat (2) tick();
            pulse_done();
            chk("rr_release", 32'(bus.grant), 32'h0);
        end
        bus.req = 3'b000;

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 0 stalls after its first byte; revoked on the 20th stall cycle.
        set_req(0, 8'h50, 1'b0);
        set_req(1, 8'h60, 1'b1);
        bus.req = 3'b011;
        tick();
        chk("t5_grant", 32'(bus.grant), 32'h1);
        wait_start("t5", n);
        chk("t5_byte", 32'(bus.tx_byte), 32'h50);
        chk("t5_ack",  32'(bus.req_ack), 32'h1);
        bus.req[0] = 1'b0;
        pulse_done();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.timeout_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("t5_tmo_cycle", 32'(n),            32'd20);
        chk("t5_tmo_grant", 32'(bus.grant),    32'h0);
        chk("t5_tmo_ack",   32'(bus.req_ack),  32'h0);
        chk("t5_tmo_start", 32'(bus.tx_start), 32'h0);
        tick();
        chk("t5_next_grant", 32'(bus.grant),        32'h2);
        chk("t5_tmo_pulse",  32'(bus.timeout_tick), 32'h0);
        wait_start("t5b", n);
        chk("t5b_byte", 32'(bus.tx_byte), 32'h60);
        chk("t5b_ack",  32'(bus.req_ack), 32'h2);
        bus.req = 3'b000;
        pulse_done();
        chk("t5b_release", 32'(bus.grant), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
